// File: rtl/ram_arb_pkg.sv
// Shared types for the two-master RAM arbiter.
// FSM states, byte-strobe encodings and owner IDs.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CMD,
        ST_RDWAIT,
        ST_RDRET
    } state_e;

    typedef enum logic {
        OWN_M0 = 1'b0,
        OWN_M1 = 1'b1
    } owner_e;

    localparam logic [3:0] BE_READ  = 4'h0;
    localparam logic [3:0] BE_WRITE = 4'hF;

    // The RAM only supports whole-word accesses.
    function automatic logic be_ok(input logic [3:0] be);
        return (be == BE_READ) || (be == BE_WRITE);
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Per-master request/response bundle for the RAM arbiter.
// The master drives the request side; the arbiter drives the responses.
interface ram_arb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req;
    logic [3:0]        be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              err;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output be,
        output addr,
        output wdata,
        input  gnt,
        input  err,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  be,
        input  addr,
        input  wdata,
        output gnt,
        output err,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin picker; remembers the last master it selected.
// On a tie the master that did not win last time is picked.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_p,
    input  logic [1:0] i_req,
    input  logic       i_upd,
    output logic [1:0] o_gnt_oh,
    output owner_e     o_owner
);

    owner_e r_last;

    always_comb begin
        o_owner  = OWN_M0;
        o_gnt_oh = 2'b00;
        unique case (i_req)
            2'b01: o_owner = OWN_M0;
            2'b10: o_owner = OWN_M1;
            2'b11: begin
                if (r_last == OWN_M0)
                    o_owner = OWN_M1;
                else
                    o_owner = OWN_M0;
            end
            default: o_owner = OWN_M0;
        endcase
        if (|i_req) begin
            if (o_owner == OWN_M1)
                o_gnt_oh = 2'b10;
            else
                o_gnt_oh = 2'b01;
        end
    end

    // Reset to M1 so that M0 wins the first tie.
    always_ff @(posedge i_clk or posedge i_rst_p) begin
        if (i_rst_p)
            r_last <= OWN_M1;
        else if (i_upd && (|i_req))
            r_last <= o_owner;
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises two masters onto a single-port 2048x32 RAM.
// One access in flight; illegal requests are rejected from IDLE.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int DEPTH_W = 11
) (
    input  logic              ram_clk,
    input  logic              ram_rst_p,
    ram_arb_if.slave          m0,
    ram_arb_if.slave          m1,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr,
    input  logic [DATA_W-1:0] ram_rd
);

    state_e            r_state;
    owner_e            r_owner;
    logic              r_is_rd;
    logic              r_en;
    logic [3:0]        r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wr;
    logic              r_rv0;
    logic              r_rv1;
    logic [DATA_W-1:0] r_rd0;
    logic [DATA_W-1:0] r_rd1;

    logic [1:0]        w_req;
    logic [1:0]        w_pick;
    owner_e            w_win;
    logic [3:0]        w_be;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;
    logic              w_idle;
    logic              w_any;
    logic              w_in_range;
    logic              w_legal;
    logic              w_gnt;
    logic              w_err;

    assign w_req  = {m1.req, m0.req};
    assign w_idle = (r_state == ST_IDLE);
    assign w_any  = |w_pick;

    rr_arb2 u_arb (
        .i_clk    (ram_clk),
        .i_rst_p  (ram_rst_p),
        .i_req    (w_req),
        .i_upd    (w_idle),
        .o_gnt_oh (w_pick),
        .o_owner  (w_win)
    );

    assign w_be    = (w_win == OWN_M1) ? m1.be    : m0.be;
    assign w_addr  = (w_win == OWN_M1) ? m1.addr  : m0.addr;
    assign w_wdata = (w_win == OWN_M1) ? m1.wdata : m0.wdata;

    assign w_in_range = ((w_addr >> DEPTH_W) == '0);
    assign w_legal    = be_ok(w_be) && w_in_range;

    // Accept/reject are decided combinationally while IDLE.
    assign w_gnt = w_idle & w_any & w_legal;
    assign w_err = w_idle & w_any & ~w_legal;

    assign m0.gnt    = w_gnt & w_pick[0];
    assign m1.gnt    = w_gnt & w_pick[1];
    assign m0.err    = w_err & w_pick[0];
    assign m1.err    = w_err & w_pick[1];
    assign m0.rvalid = r_rv0;
    assign m1.rvalid = r_rv1;
    assign m0.rdata  = r_rd0;
    assign m1.rdata  = r_rd1;

    assign ram_en   = r_en;
    assign ram_we   = r_we;
    assign ram_addr = r_addr;
    assign ram_wr   = r_wr;

    always_ff @(posedge ram_clk or posedge ram_rst_p) begin
        if (ram_rst_p) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_M0;
            r_is_rd <= 1'b0;
            r_en    <= 1'b0;
            r_we    <= BE_READ;
            r_addr  <= '0;
            r_wr    <= '0;
            r_rv0   <= 1'b0;
            r_rv1   <= 1'b0;
            r_rd0   <= '0;
            r_rd1   <= '0;
        end else begin
            r_rv0 <= 1'b0;
            r_rv1 <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_gnt) begin
                        r_en    <= 1'b1;
                        r_we    <= (w_be == BE_WRITE) ? BE_WRITE : BE_READ;
                        r_addr  <= w_addr;
                        r_wr    <= w_wdata;
                        r_owner <= w_win;
                        r_is_rd <= (w_be == BE_READ);
                        r_state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    r_en    <= 1'b0;
                    r_we    <= BE_READ;
                    r_state <= r_is_rd ? ST_RDWAIT : ST_IDLE;
                end
                // RAM output register holds the word during this cycle.
                ST_RDWAIT: begin
                    if (r_owner == OWN_M1) begin
                        r_rd1 <= ram_rd;
                        r_rv1 <= 1'b1;
                    end else begin
                        r_rd0 <= ram_rd;
                        r_rv0 <= 1'b1;
                    end
                    r_state <= ST_RDRET;
                end
                ST_RDRET: begin
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural 2048x32 RAM.
// Vector table plus round-robin, err-then-grant and mid-read reset sequences.
module tb_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr;
    logic [31:0] ram_wr;
    logic [31:0] ram_rd;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_rd0 = 32'h0;
    logic [31:0] exp_rd1 = 32'h0;

    ram_arb_if #(.DATA_W(32), .ADDR_W(32)) m0_if ();
    ram_arb_if #(.DATA_W(32), .ADDR_W(32)) m1_if ();

    ram_arbiter #(
        .DATA_W  (32),
        .ADDR_W  (32),
        .DEPTH_W (11)
    ) dut (
        .ram_clk   (clk),
        .ram_rst_p (rst),
        .m0        (m0_if.slave),
        .m1        (m1_if.slave),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wr    (ram_wr),
        .ram_rd    (ram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: registered read, lower half cleared by reset.
    logic [31:0] mem [0:2047];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++)
                mem[i] <= 32'h0;
            ram_rd <= 32'h0;
        end else if (ram_en) begin
            if (ram_we == 4'hF)
                mem[ram_addr[10:0]] <= ram_wr;
            ram_rd <= mem[ram_addr[10:0]];
        end else begin
            ram_rd <= 32'h0;
        end
    end

    typedef struct {
        logic        req0;
        logic [3:0]  be0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic        req1;
        logic [3:0]  be1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic [1:0]  gnt;
        logic [1:0]  err;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drop_reqs();
        m0_if.req = 1'b0;
        m1_if.req = 1'b0;
    endtask

    function automatic logic [31:0] flags_g();
        return {30'h0, m1_if.gnt, m0_if.gnt};
    endfunction

    function automatic logic [31:0] flags_e();
        return {30'h0, m1_if.err, m0_if.err};
    endfunction

    function automatic logic [31:0] flags_v();
        return {30'h0, m1_if.rvalid, m0_if.rvalid};
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        logic own1;
        logic wr;
        logic rdop;
        string nm;
        nm = $sformatf("v%0d", idx);
        m0_if.req = v.req0; m0_if.be = v.be0;
        m0_if.addr = v.a0;  m0_if.wdata = v.d0;
        m1_if.req = v.req1; m1_if.be = v.be1;
        m1_if.addr = v.a1;  m1_if.wdata = v.d1;
        #2;
        chk({nm, "_gnt"}, flags_g(), {30'h0, v.gnt});
        chk({nm, "_err"}, flags_e(), {30'h0, v.err});
        own1 = v.gnt[1] | v.err[1];
        wr   = (v.gnt != 2'b00) && ((own1 ? v.be1 : v.be0) == 4'hF);
        rdop = (v.gnt != 2'b00) && !wr;
        tick();
        drop_reqs();
        chk({nm, "_en"}, {31'h0, ram_en}, {31'h0, (v.gnt != 2'b00)});
        if (v.gnt != 2'b00) begin
            chk({nm, "_we"}, {28'h0, ram_we}, wr ? 32'hF : 32'h0);
            chk({nm, "_addr"}, ram_addr, own1 ? v.a1 : v.a0);
            if (wr)
                chk({nm, "_wr"}, ram_wr, own1 ? v.d1 : v.d0);
        end
        if (wr) begin
            tick();
            chk({nm, "_en_off"}, {31'h0, ram_en}, 32'h0);
        end else if (rdop) begin
            tick();
            chk({nm, "_rv_early"}, flags_v(), 32'h0);
            if (own1)
                exp_rd1 = v.rd;
            else
                exp_rd0 = v.rd;
            tick();
            chk({nm, "_rv"}, flags_v(), own1 ? 32'h2 : 32'h1);
            chk({nm, "_rd0"}, m0_if.rdata, exp_rd0);
            chk({nm, "_rd1"}, m1_if.rdata, exp_rd1);
            tick();
            chk({nm, "_rv_off"}, flags_v(), 32'h0);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_en"}, {31'h0, ram_en}, 32'h0);
        chk({nm, "_we"}, {28'h0, ram_we}, 32'h0);
        chk({nm, "_addr"}, ram_addr, 32'h0);
        chk({nm, "_wr"}, ram_wr, 32'h0);
        chk({nm, "_rv"}, flags_v(), 32'h0);
        chk({nm, "_rd0"}, m0_if.rdata, 32'h0);
        chk({nm, "_rd1"}, m1_if.rdata, 32'h0);
    endtask

    initial begin
        // req0 be0 a0 d0 | req1 be1 a1 d1 | gnt err rd
        vecs[0]  = '{1, 4'hF, 1, 32'h11111111, 0, 4'h0, 0, 0, 2'b01, 2'b00, 0};
        vecs[1]  = '{0, 4'h0, 0, 0, 1, 4'hF, 2, 32'h22222222, 2'b10, 2'b00, 0};
        vecs[2]  = '{0, 4'h0, 0, 0, 1, 4'hF, 5, 32'hDEADBEEF, 2'b10, 2'b00, 0};
        vecs[3]  = '{1, 4'h0, 5, 0, 0, 4'h0, 0, 0, 2'b01, 2'b00, 32'hDEADBEEF};
        vecs[4]  = '{1, 4'h3, 3, 32'hFFFF, 0, 4'h0, 0, 0, 2'b00, 2'b01, 0};
        vecs[5]  = '{1, 4'h0, 3, 0, 0, 4'h0, 0, 0, 2'b01, 2'b00, 0};
        vecs[6]  = '{0, 4'h0, 0, 0, 1, 4'h8, 7, 32'h77, 2'b00, 2'b10, 0};
        vecs[7]  = '{1, 4'hF, 2048, 32'h55, 0, 4'h0, 0, 0, 2'b00, 2'b01, 0};
        vecs[8]  = '{0, 4'h0, 0, 0, 1, 4'hF, 2047, 32'h12345678, 2'b10, 2'b00, 0};
        vecs[9]  = '{1, 4'h0, 2047, 0, 0, 4'h0, 0, 0, 2'b01, 2'b00, 32'h12345678};
        vecs[10] = '{0, 4'h0, 0, 0, 1, 4'hF, 10, 32'hAAAA5555, 2'b10, 2'b00, 0};
        vecs[11] = '{1, 4'h0, 10, 0, 1, 4'h0, 5, 0, 2'b01, 2'b00, 32'hAAAA5555};
        vecs[12] = '{0, 4'h0, 0, 0, 1, 4'h0, 5, 0, 2'b10, 2'b00, 32'hDEADBEEF};
        vecs[13] = '{1, 4'h0, 2, 0, 0, 4'h0, 0, 0, 2'b01, 2'b00, 32'h22222222};
        vecs[14] = '{1, 4'h0, 10, 0, 1, 4'h0, 2, 0, 2'b01, 2'b00, 0};
        vecs[15] = '{0, 4'h0, 0, 0, 1, 4'h0, 2, 0, 2'b10, 2'b00, 0};

        rst = 1'b1;
        drop_reqs();
        m0_if.be = 4'h0; m0_if.addr = 0; m0_if.wdata = 0;
        m1_if.be = 4'h0; m1_if.addr = 0; m1_if.wdata = 0;
        @(negedge clk);
        tick();
        tick();
        #2;
        chk_all_zero("reset");
        chk("reset_gnt", flags_g(), 32'h0);
        chk("reset_err", flags_e(), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 2; i++)
            run_vec(vecs[i], i);

        // Both masters keep reading: grants alternate, m0 first.
        m0_if.req = 1'b1; m0_if.be = 4'h0; m0_if.addr = 1;
        m1_if.req = 1'b1; m1_if.be = 4'h0; m1_if.addr = 2;
        for (int g = 0; g < 8; g++) begin
            logic got;
            got = 1'b0;
            for (int c = 0; c < 6 && !got; c++) begin
                #2;
                if (m0_if.gnt | m1_if.gnt)
                    got = 1'b1;
                else
                    tick();
            end
            chk($sformatf("rr%0d_wait", g), {31'h0, got}, 32'h1);
            chk($sformatf("rr%0d_gnt", g), flags_g(),
                (g % 2 == 1) ? 32'h2 : 32'h1);
            if (g % 2 == 1)
                exp_rd1 = 32'h22222222;
            else
                exp_rd0 = 32'h11111111;
            tick();
            #2;
            chk($sformatf("rr%0d_busy", g), flags_g(), 32'h0);
            tick();
            tick();
            chk($sformatf("rr%0d_rv", g), flags_v(),
                (g % 2 == 1) ? 32'h2 : 32'h1);
            chk($sformatf("rr%0d_rd0", g), m0_if.rdata, exp_rd0);
            chk($sformatf("rr%0d_rd1", g), m1_if.rdata, exp_rd1);
            tick();
        end
        drop_reqs();
        tick();

        for (int i = 2; i < 14; i++)
            run_vec(vecs[i], i);

        // m1 out of range wins the tie and is rejected; m0 gets in next cycle.
        m0_if.req = 1'b1; m0_if.be = 4'h0; m0_if.addr = 2047;
        m1_if.req = 1'b1; m1_if.be = 4'h0; m1_if.addr = 2048;
        #2;
        chk("oor_err", flags_e(), 32'h2);
        chk("oor_gnt", flags_g(), 32'h0);
        tick();
        m1_if.req = 1'b0;
        chk("oor_en", {31'h0, ram_en}, 32'h0);
        #2;
        chk("oor_next_gnt", flags_g(), 32'h1);
        chk("oor_next_err", flags_e(), 32'h0);
        tick();
        m0_if.req = 1'b0;
        chk("oor_ram_addr", ram_addr, 32'd2047);
        exp_rd0 = 32'h12345678;
        tick();
        tick();
        chk("oor_rv", flags_v(), 32'h1);
        chk("oor_rd0", m0_if.rdata, exp_rd0);
        tick();

        // Reset while the read sits in RDWAIT.
        m0_if.req = 1'b1; m0_if.be = 4'h0; m0_if.addr = 10;
        #2;
        chk("rst_seq_gnt", flags_g(), 32'h1);
        tick();
        m0_if.req = 1'b0;
        chk("rst_seq_en", {31'h0, ram_en}, 32'h1);
        tick();
        rst = 1'b1;
        #2;
        chk_all_zero("rst_mid");
        exp_rd0 = 32'h0;
        exp_rd1 = 32'h0;
        tick();
        chk("rst_hold_rv", flags_v(), 32'h0);
        rst = 1'b0;
        tick();
        chk("rst_after_rv0", flags_v(), 32'h0);
        tick();
        chk("rst_after_rv1", flags_v(), 32'h0);

        for (int i = 14; i < 16; i++)
            run_vec(vecs[i], i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-master arbiter/sequencer in front of the single-port 2048x32 word RAM.
- Master 0 is the instruction-fetch side; master 1 is the load/store side.
- Serialises their requests with round-robin fairness and drives the RAM's en/we/addr/wr pins.
- Captures the RAM's registered read data and returns it to the owning master.
- Rejects accesses the RAM cannot honour: partial byte strobes and out-of-range addresses.

Parameters:
- DATA_W, 32, data width of masters and RAM.
- ADDR_W, 32, master/RAM address port width (word address).
- DEPTH_W, 11, log2 of RAM depth; addresses >= 2**DEPTH_W are out of range.

Ports:
- ram_clk  in  1  clock
- ram_rst_p  in  1  reset
- m0_req  in  1  master 0 request; held until m0_gnt or m0_err
- m0_be  in  4  byte strobes; 0000 = read, 1111 = write, anything else illegal
- m0_addr  in  ADDR_W  word address
- m0_wdata  in  DATA_W  write data
- m0_gnt  out  1  one-cycle accept pulse
- m0_err  out  1  one-cycle reject pulse
- m0_rvalid  out  1  one-cycle read-data-valid pulse
- m0_rdata  out  DATA_W  read data, held until next rvalid
- m1_req, m1_be, m1_addr, m1_wdata, m1_gnt, m1_err, m1_rvalid, m1_rdata: same as master 0
- ram_en  out  1  RAM enable
- ram_we  out  4  RAM write enable; only 4'h0 or 4'hF is ever driven
- ram_addr  out  ADDR_W  RAM word address
- ram_wr  out  DATA_W  RAM write data
- ram_rd  in  DATA_W  RAM registered read data

Interface decision: reset ram_rst_p, asynchronous, active-high; clock ram_clk. All outputs are registered except gnt/err, which are combinational from IDLE state.

Behaviour:
- Reset values: ram_en=0, ram_we=0, ram_addr=0, ram_wr=0, all gnt/err/rvalid=0, rdata=0, state=IDLE, last_owner=1 (master 0 wins first).
- FSM states: IDLE, CMD, RDWAIT, RDRET.
- IDLE, winner selection:
  - Single requester wins.
  - If both request, the master other than last_owner wins.
- IDLE, illegal winner request (be not 0000/1111, or addr >= 2**DEPTH_W):
  - err pulses this cycle, no gnt, no RAM access.
  - last_owner updates, so the other master is not starved.
  - State stays IDLE.
- IDLE, legal winner request:
  - gnt pulses this cycle; last_owner and owner latch the winner.
  - At the edge: ram_en<=1, ram_we<=(be==1111 ? F : 0), ram_addr<=addr, ram_wr<=wdata; next state CMD.
- CMD: RAM performs the access at this edge.
  - ram_en<=0, ram_we<=0.
  - Next state: RDWAIT for a read, IDLE for a write.
- RDWAIT: ram_rd is valid this cycle; owner's rdata<=ram_rd; next state RDRET.
- RDRET: owner's rvalid=1 for exactly this cycle; next state IDLE.
- Timing: gnt in cycle T; write committed at edge T+2; read rvalid in cycle T+3.
- Throughput: write 2 cycles, read 4 cycles, back-to-back. At most one outstanding access.
- No new grant while not IDLE; req may be held or changed freely while not IDLE.
- A master may not withdraw req before gnt/err. If it does, it is simply not selected.
- Non-owner rdata is never modified.
- ram_en is 0 in every cycle except CMD. This guarantees no spurious RAM accesses, and the RAM's read port auto-clears when disabled.
- Reset mid-operation: return to IDLE immediately. A pending read gets no rvalid; a write already in CMD may or may not commit.
- RAM reset clears only words 0..1023. Upper-half contents are undefined after reset.

Decomposition:
- Package ram_arb_pkg: state enum (IDLE, CMD, RDWAIT, RDRET), BE_READ=4'h0, BE_WRITE=4'hF, owner encoding.
- One sub-module, rr_arb2: 2-way round-robin picker with inputs req[1:0], last_owner and outputs gnt_oh[1:0], owner. Combinational plus the last_owner register.
- Legality check and FSM live in ram_arbiter.

Test Plan:
- Reset, then m1 writes be=1111 addr=5 data=DEADBEEF -> m1_gnt pulse, ram_en=1 & ram_we=F one cycle later. m0 then reads addr 5 -> m0_rvalid 3 cycles after m0_gnt, m0_rdata=DEADBEEF.
- Both masters request reads continuously for 8 grants -> grants alternate m0,m1,m0,… starting with m0. Each rvalid reaches only the owner; the other's rdata is unchanged.
- m0 be=0011 addr=3 -> m0_err pulse, no gnt, ram_en stays 0, addr 3 content unchanged on a later read.
- m1 read addr=2048 (DEPTH_W=11) -> m1_err, no RAM access; a simultaneous m0 legal request is granted next cycle.
- Assert ram_rst_p in RDWAIT of an m0 read -> all outputs 0 next cycle, no m0_rvalid. After release, a fresh read of addr 10 returns 0.
- Write addr 2047=0x12345678 then read 2047 -> 0x12345678 (top-of-range boundary).
